// File: rtl/west_edge_feeder.sv
// West-edge sequencer for the mac_tile array: accepts row-parallel words, tags them as
// kernel-load or execute, and presents them to the array rows with a one-cycle-per-row skew.
module west_edge_feeder #(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [len_bw-1:0]   exec_len,
    input  logic [row*bw-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [row*bw-1:0]   out_e,
    output logic [row*2-1:0]    inst_e,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [len_bw-1:0] cnt;
    logic [len_bw-1:0] len_q;
    logic              done_q;
    logic              accept;
    logic              load_last;
    logic              exec_last;
    logic              drain_last;
    logic [row*bw-1:0] inj_data;
    logic [1:0]        inj_inst;

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are both high;
    // in_ready depends on state only, so the source may present data without waiting on it.
    assign in_ready   = (state == LOAD) || (state == EXEC);
    assign accept     = in_ready && in_valid;
    assign load_last  = accept && (cnt == len_bw'(col - 1));
    assign exec_last  = accept && (cnt == len_q - 1'b1);
    assign drain_last = (cnt == len_bw'(row - 1));
    assign busy       = (state != IDLE);
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (load_last) begin
                    state_next = (len_q == '0) ? DRAIN : EXEC;
                end
            end
            EXEC: begin
                if (exec_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One counter serves every phase: accepted words in LOAD/EXEC, elapsed cycles in DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DRAIN) && drain_last;
            if (state == IDLE && start) begin
                len_q <= exec_len;
            end
            if (state != state_next) begin
                cnt <= '0;
            end else if (accept || state == DRAIN) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign inj_data = accept ? in_data : '0;
    assign inj_inst = !accept ? 2'b00 : ((state == LOAD) ? 2'b01 : 2'b10);

    // Lane r carries its own chain of r+1 registers, so lane 0 has one cycle of latency.
    for (genvar r = 0; r < row; r++) begin : g_lane
        logic [bw-1:0] d_sr [0:r];
        logic [1:0]    i_sr [0:r];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= r; k++) begin
                    d_sr[k] <= '0;
                    i_sr[k] <= '0;
                end
            end else begin
                d_sr[0] <= inj_data[r*bw +: bw];
                i_sr[0] <= inj_inst;
                for (int k = 1; k <= r; k++) begin
                    d_sr[k] <= d_sr[k-1];
                    i_sr[k] <= i_sr[k-1];
                end
            end
        end

        assign out_e[r*bw +: bw] = d_sr[r];
        assign inst_e[2*r +: 2]  = i_sr[r];
    end

endmodule
